tcb_lib_register_response: RTL and testbench

//  TCB register slice on the response path, the counterpart of the request-path slice.

---
 rtl/tcb_lib_register_response_pkg.sv | 18 +
 rtl/tcb_lib_register_response_if.sv | 20 ++
 rtl/tcb_lib_register_response_delay_line.sv | 31 +++
 rtl/tcb_lib_register_response.sv | 84 ++++++++
 tb/tb_tcb_lib_register_response.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/tcb_lib_register_response_pkg.sv
// Shared TCB widths, limits and the response-tracker entry type.
package tcb_lib_register_response_pkg;

  localparam int unsigned ADR_W   = 32;
  localparam int unsigned DAT_W   = 32;
  localparam int unsigned BEW     = DAT_W / 8;
  localparam int unsigned DLY_MAX = 7;

  // One tracker entry: transfer happened, it was a read, and which bytes it enabled
  typedef struct packed {
    logic           trn;
    logic           ren;
    logic [BEW-1:0] ben;
  } tcb_trk_t;

  localparam int unsigned TRK_W = $bits(tcb_trk_t);

endpackage : tcb_lib_register_response_pkg

// File: rtl/tcb_lib_register_response_if.sv
// TCB bus interface; DLY is the response delay seen on this side of the bus.
interface tcb_lib_register_response_if #(
  parameter int unsigned DLY = 1,
  parameter int unsigned ADR = tcb_lib_register_response_pkg::ADR_W,
  parameter int unsigned DAT = tcb_lib_register_response_pkg::DAT_W
);

  logic             vld;
  logic             wen;
  logic [ADR-1:0]   adr;
  logic [DAT/8-1:0] ben;
  logic [DAT-1:0]   wdt;
  logic             rdy;
  logic [DAT-1:0]   rdt;
  logic             err;

  modport master (output vld, wen, adr, ben, wdt, input  rdy, rdt, err);
  modport slave  (input  vld, wen, adr, ben, wdt, output rdy, rdt, err);

endinterface : tcb_lib_register_response_if

// File: rtl/tcb_lib_register_response_delay_line.sv
// Fixed-depth shift register with async clear; depth 0 degenerates to a wire.
module tcb_lib_register_response_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst_n};
    assign o_dat    = i_dat;
  end else begin : g_shift
    logic [WIDTH-1:0] r_stg [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) r_stg[i] <= '0;
      end else begin
        r_stg[0] <= i_dat;
        for (int i = 1; i < int'(DEPTH); i++) r_stg[i] <= r_stg[i-1];
      end
    end

    assign o_dat = r_stg[DEPTH-1];
  end

endmodule : tcb_lib_register_response_delay_line

// File: rtl/tcb_lib_register_response.sv
// TCB response-path register slice: request passes straight through,
// read data and error are captured one cycle after the downstream response.
module tcb_lib_register_response
  import tcb_lib_register_response_pkg::*;
#(
  parameter int unsigned GRN = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  tcb_lib_register_response_if.slave   sub,
  tcb_lib_register_response_if.master  man
);

  localparam int unsigned DLY_SUB = sub.DLY;
  localparam int unsigned DLY_MAN = man.DLY;
  localparam int unsigned GRN_L   = (GRN == 0) ? 1 : GRN;
  localparam int unsigned GRP_N   = BEW / GRN_L;
  localparam int unsigned GRP_W   = GRN_L * 8;

  // Elaboration-time configuration checks
  if (DLY_SUB != DLY_MAN + 1) begin : g_chk_dly
    $fatal(1, "DLY_SUB must equal DLY_MAN+1");
  end
  if (DLY_MAN > DLY_MAX) begin : g_chk_max
    $fatal(1, "DLY_MAN exceeds DLY_MAX");
  end
  if (sub.ADR != man.ADR || sub.DAT != man.DAT || sub.DAT != DAT_W) begin : g_chk_wid
    $fatal(1, "ADR/DAT mismatch between sub and man");
  end
  if (GRN == 0 || (BEW % GRN_L) != 0) begin : g_chk_grn
    $fatal(1, "DAT/8 must be divisible by GRN");
  end

  // Request path: zero-latency pass-through
  assign man.vld = sub.vld;
  assign man.wen = sub.wen;
  assign man.adr = sub.adr;
  assign man.ben = sub.ben;
  assign man.wdt = sub.wdt;
  assign sub.rdy = man.rdy;

  logic             w_trn;
  tcb_trk_t         w_req;
  tcb_trk_t         w_rsp;
  logic [TRK_W-1:0] w_rsp_vec;

  assign w_trn     = man.vld & man.rdy;
  assign w_req.trn = w_trn;
  assign w_req.ren = ~man.wen;
  assign w_req.ben = man.ben;

  tcb_lib_register_response_delay_line #(
    .WIDTH (TRK_W),
    .DEPTH (DLY_MAN)
  ) u_trk (
    .clk   (clk),
    .rst_n (rst_n),
    .i_dat (TRK_W'(w_req)),
    .o_dat (w_rsp_vec)
  );

  assign w_rsp = tcb_trk_t'(w_rsp_vec);

  logic [DAT_W-1:0] r_rdt;
  logic             r_err;

  // Capture the maturing response; unread byte groups keep their value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdt <= '0;
      r_err <= 1'b0;
    end else if (w_rsp.trn) begin
      r_err <= man.err;
      for (int g = 0; g < int'(GRP_N); g++) begin
        if (w_rsp.ren && |w_rsp.ben[g*GRN_L +: GRN_L])
          r_rdt[g*GRP_W +: GRP_W] <= man.rdt[g*GRP_W +: GRP_W];
      end
    end
  end

  assign sub.rdt = r_rdt;
  assign sub.err = r_err;

endmodule : tcb_lib_register_response

// File: tb/tb_tcb_lib_register_response.sv
// Directed bench: two slices (GRN=1 DLY 2/1, GRN=2 DLY 4/3) in front of simple pipelined memories.
module tb_tcb_lib_register_response;

  localparam int unsigned D1 = 1;
  localparam int unsigned D2 = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic man_rdy1, man_rdy2;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  tcb_lib_register_response_if #(.DLY(D1+1)) s1 ();
  tcb_lib_register_response_if #(.DLY(D1))   m1 ();
  tcb_lib_register_response_if #(.DLY(D2+1)) s2 ();
  tcb_lib_register_response_if #(.DLY(D2))   m2 ();

  tcb_lib_register_response #(.GRN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sub(s1.slave), .man(m1.master));
  tcb_lib_register_response #(.GRN(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sub(s2.slave), .man(m2.master));

  // Downstream memories: respond D cycles after a transfer, garbage otherwise
  logic [31:0] mem1 [64];
  logic [31:0] mem2 [64];
  logic [31:0] p1_rdt [D1];
  logic        p1_err [D1];
  logic [31:0] p2_rdt [D2];
  logic        p2_err [D2];

  assign m1.rdy = man_rdy1;
  assign m2.rdy = man_rdy2;
  assign m1.rdt = p1_rdt[D1-1];
  assign m1.err = p1_err[D1-1];
  assign m2.rdt = p2_rdt[D2-1];
  assign m2.err = p2_err[D2-1];

  always @(posedge clk) begin
    for (int i = D1-1; i > 0; i--) begin
      p1_rdt[i] <= p1_rdt[i-1];
      p1_err[i] <= p1_err[i-1];
    end
    p1_rdt[0] <= 32'hDEAD_BEEF;
    p1_err[0] <= 1'b1;
    if (m1.vld && m1.rdy) begin
      p1_err[0] <= (m1.adr == 32'h40);
      if (m1.wen) begin
        for (int b = 0; b < 4; b++)
          if (m1.ben[b]) mem1[m1.adr[7:2]][8*b +: 8] <= m1.wdt[8*b +: 8];
      end else begin
        p1_rdt[0] <= mem1[m1.adr[7:2]];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = D2-1; i > 0; i--) begin
      p2_rdt[i] <= p2_rdt[i-1];
      p2_err[i] <= p2_err[i-1];
    end
    p2_rdt[0] <= 32'hDEAD_BEEF;
    p2_err[0] <= 1'b1;
    if (m2.vld && m2.rdy) begin
      p2_err[0] <= (m2.adr == 32'h40);
      if (m2.wen) begin
        for (int b = 0; b < 4; b++)
          if (m2.ben[b]) mem2[m2.adr[7:2]][8*b +: 8] <= m2.wdt[8*b +: 8];
      end else begin
        p2_rdt[0] <= mem2[m2.adr[7:2]];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int d, input logic v, input logic w,
                     input logic [31:0] a, input logic [3:0] b, input logic [31:0] wd);
    if (d == 1) begin
      s1.vld = v; s1.wen = w; s1.adr = a; s1.ben = b; s1.wdt = wd;
    end else begin
      s2.vld = v; s2.wen = w; s2.adr = a; s2.ben = b; s2.wdt = wd;
    end
  endtask

  task automatic idle(input int d);
    drv(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    man_rdy1 = 1'b1;
    man_rdy2 = 1'b1;
    idle(1);
    idle(2);
    repeat (2) tick();
    chk("rst_rdt1", s1.rdt, 32'h0);
    chk("rst_err1", 32'(s1.err), 32'h0);
    chk("rst_rdt2", s2.rdt, 32'h0);
    chk("rst_err2", 32'(s2.err), 32'h0);
    rst_n = 1'b1;
    tick();

    // write then read, response exactly two cycles after the read transfer
    drv(1, 1'b1, 1'b1, 32'h10, 4'hF, 32'h0123_4567);
    tick();
    drv(1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    tick();
    idle(1);
    chk("t1_early_rdt", s1.rdt, 32'h0);
    tick();
    chk("t1_rdt", s1.rdt, 32'h0123_4567);
    chk("t1_err", 32'(s1.err), 32'h0);

    // partial read keeps unread bytes (GRN=1)
    drv(1, 1'b1, 1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF);
    tick();
    drv(1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    tick();
    drv(1, 1'b1, 1'b0, 32'h10, 4'b0011, 32'h0);
    tick();
    idle(1);
    chk("t2_full", s1.rdt, 32'hFFFF_FFFF);
    tick();
    chk("t2_part", s1.rdt, 32'hFFFF_4567);

    // eight back-to-back reads
    for (int i = 0; i < 8; i++) begin
      drv(1, 1'b1, 1'b1, 32'(4*i), 4'hF, 32'hC0DE_0000 | 32'(i));
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      if (k < 8) drv(1, 1'b1, 1'b0, 32'(4*k), 4'hF, 32'h0);
      else idle(1);
      if (k >= 2) chk($sformatf("t3_b2b%0d", k-2), s1.rdt, 32'hC0DE_0000 | 32'(k-2));
      tick();
    end

    // write error propagates, rdt untouched, next read clears err
    drv(1, 1'b1, 1'b1, 32'h40, 4'hF, 32'h1111_1111);
    tick();
    idle(1);
    tick();
    chk("t4_err", 32'(s1.err), 32'h1);
    chk("t4_rdt_hold", s1.rdt, 32'hC0DE_0007);
    drv(1, 1'b1, 1'b0, 32'h08, 4'hF, 32'h0);
    tick();
    idle(1);
    tick();
    chk("t4_err_clr", 32'(s1.err), 32'h0);
    chk("t4_rdt", s1.rdt, 32'hC0DE_0002);

    // stalled request: rdy low for three cycles
    drv(1, 1'b1, 1'b0, 32'h14, 4'hF, 32'h0);
    man_rdy1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t5_rdy_low%0d", c), 32'(s1.rdy), 32'h0);
      tick();
    end
    man_rdy1 = 1'b1;
    chk("t5_rdy_high", 32'(s1.rdy), 32'h1);
    tick();
    idle(1);
    chk("t5_early", s1.rdt, 32'hC0DE_0002);
    tick();
    chk("t5_rdt", s1.rdt, 32'hC0DE_0005);
    chk("t5_err", 32'(s1.err), 32'h0);
    tick();
    chk("t5_single", s1.rdt, 32'hC0DE_0005);

    // GRN=2, partial read with ben=0001 keeps the upper half
    drv(2, 1'b1, 1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF);
    tick();
    drv(2, 1'b1, 1'b1, 32'h10, 4'hF, 32'h0123_4567);
    tick();
    drv(2, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    tick();
    drv(2, 1'b1, 1'b0, 32'h10, 4'b0001, 32'h0);
    tick();
    idle(2);
    repeat (2) tick();
    chk("t2b_full", s2.rdt, 32'hFFFF_FFFF);
    tick();
    chk("t2b_part", s2.rdt, 32'hFFFF_4567);

    // reset with a read in flight (DLY_MAN=3)
    drv(2, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    tick();
    idle(2);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rdt", s2.rdt, 32'h0);
    chk("t6_rst_err", 32'(s2.err), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("t6_no_upd%0d", c), s2.rdt, 32'h0);
    end
    drv(2, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    tick();
    idle(2);
    repeat (3) tick();
    chk("t6_fresh_rdt", s2.rdt, 32'h0123_4567);
    chk("t6_fresh_err", 32'(s2.err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule : tb_tcb_lib_register_response
